// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD 7-segment display blocks: digit type,
// display width and the active-low segment patterns ({g,f,e,d,c,b,a}).
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Codes 10..15 are not valid BCD and are shown as a dash so a corrupted
// counter value is visible rather than silently mis-rendered.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    // Table lookup from digit value to segment pattern
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 8-digit common-anode 7-segment driver for a packed BCD word.
// One digit is lit per refresh slot, with an all-dark guard interval at the
// start of each slot to suppress ghosting. The BCD word is captured once per
// scan frame so a frame never mixes two values. In edit mode (load) the digit
// selected by bitSW blinks.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (digits 7..1); digit 0 is always shown.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYC    = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           bcd_in,
    input  logic                  load,
    input  logic [IDX_W-1:0]      bitSW,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] GUARD_END = PRE_W'(GUARD_CYC);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      prescaler;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           snapshot;
    logic [FRM_W-1:0]      frame_cnt;
    logic                  blink_phase;

    logic                  tick;
    logic                  frame_wrap;
    logic                  in_guard;
    logic                  blink_blank;
    logic                  lz_blank;
    digit_t                cur_digit;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;

    assign tick       = (prescaler == PRE_LAST);
    assign frame_wrap = tick && (idx == IDX_LAST);

    // Slot prescaler: counts 0..REFRESH_DIV-1 and wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Digit index advances once per slot, wrapping 7 -> 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
    end

    // Capture the BCD word only at the frame boundary so a frame stays coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot <= '0;
        end else if (frame_wrap) begin
            snapshot <= bcd_in;
        end
    end

    // Blink timebase: toggle the phase every BLINK_FRAMES complete frames,
    // free-running so the blink is already in step when load goes high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FRM_W'(1);
            end
        end
    end

    assign cur_digit = snapshot[{idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    // Mark digits 7..1 that are zero with only zeros above them
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        lz_mask     = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zeros_above = zeros_above && (snapshot[4*i +: 4] == 4'd0);
            lz_mask[i]  = zeros_above;
        end
    end

    assign lz_blank = lz_mask[idx];
`else
    assign lz_blank = 1'b0;
`endif

    assign in_guard    = (prescaler < GUARD_END);
    assign blink_blank = load && (bitSW == idx) && blink_phase;

    // Next anode/segment pattern; blanking keeps the anode driven so
    // per-digit on-time (and so brightness) never changes
    always_comb begin
        an_next  = '1;
        seg_next = SEG_OFF;
        if (!in_guard) begin
            an_next = ~(NUM_DIGITS'(1) << idx);
            if (blink_blank || lz_blank) begin
                seg_next = SEG_OFF;
            end else begin
                seg_next = dec_seg;
            end
        end
    end

    // Registered outputs give glitch-free pad drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display with a small refresh divider.
// Expected outputs come from a time-based reference model: the number of
// clock edges since reset release determines slot, digit, frame and blink
// phase by plain arithmetic. Honours LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_scan_display;

    localparam int RD  = 4;
    localparam int GC  = 1;
    localparam int BF  = 2;
    localparam int FRM = RD * 8;

    logic        clk;
    logic        rst;
    logic [31:0] bcd_in;
    logic        load;
    logic [2:0]  bitSW;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    bcd_scan_display #(
        .REFRESH_DIV  (RD),
        .GUARD_CYC    (GC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bcd_in (bcd_in),
        .load   (load),
        .bitSW  (bitSW),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode table (active-low {g,f,e,d,c,b,a}); 10..15 render as a dash
    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    // Reference model state
    int          n;
    logic [31:0] model_snap;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    int          m_pre;
    int          m_slot;
    int          m_dig;
    int          m_frame;
    bit          m_phase;

    // Model: after each edge the outputs show the state reached n edges after release
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n          = 0;
            model_snap = 32'd0;
            exp_an     = 8'hFF;
            exp_seg    = 7'h7F;
        end else begin
            m_pre   = n % RD;
            m_slot  = n / RD;
            m_dig   = m_slot % 8;
            m_frame = m_slot / 8;
            m_phase = ((m_frame / BF) % 2) == 1;
            if (m_pre < GC) begin
                exp_an  = 8'hFF;
                exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(8'h01 << m_dig);
                exp_seg = seg_ref[model_snap[4*m_dig +: 4]];
                if (load && (bitSW == m_dig[2:0]) && m_phase)
                    exp_seg = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
                if (m_dig > 0 && (model_snap >> (4*m_dig)) == 32'd0)
                    exp_seg = 7'h7F;
`endif
            end
            if ((n % FRM) == FRM - 1)
                model_snap = bcd_in;
            n++;
        end
    end

    task automatic applyStimulus(input logic [31:0] b, input logic ld, input logic [2:0] sw);
        bcd_in = b;
        load   = ld;
        bitSW  = sw;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (an === exp_an) else begin
            errors++;
            $error("[TB] FAIL %s an observed=%h expected=%h", tag, an, exp_an);
        end
        checks++;
        assert (seg === exp_seg) else begin
            errors++;
            $error("[TB] FAIL %s seg observed=%b expected=%b", tag, seg, exp_seg);
        end
        checks++;
        assert (dp === 1'b1) else begin
            errors++;
            $error("[TB] FAIL %s dp observed=%b expected=1", tag, dp);
        end
    endtask

    task automatic stepCycles(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    task automatic waitFramePos(input int p, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRM; i++) begin
            if ((n % FRM) == p) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            checkOutput(tag);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout observed=none expected=frame_pos_%0d", tag, p);
        end
    endtask

    // Wait until the digit is displayed, then compare against a fixed pattern
    task automatic checkDigit(input int d, input logic [6:0] want, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge clk);
            checkOutput(tag);
            if (exp_an == ~(8'h01 << d)) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL %s timeout observed=none expected=digit_%0d", tag, d);
        end else begin
            assert (an === ~(8'h01 << d) && seg === want) else begin
                errors++;
                $error("[TB] FAIL %s an/seg observed=%h/%b expected=%h/%b",
                       tag, an, seg, ~(8'h01 << d), want);
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        applyStimulus(32'd0, 1'b0, 3'd0);
        repeat (3) @(negedge clk);
        checks++;
        assert (an === 8'hFF && seg === 7'h7F && dp === 1'b1) else begin
            errors++;
            $error("[TB] FAIL reset an/seg/dp observed=%h/%b/%b expected=ff/1111111/1", an, seg, dp);
        end

        // Scan: first frame shows snapshot zero, then the captured word
        rst = 1'b0;
        applyStimulus(32'h87654321, 1'b0, 3'd0);
        stepCycles(72, "scan");
        checkDigit(0, 7'b1111001, "scan_d0");
        checkDigit(7, 7'b0000000, "scan_d7");

        // Frame coherence: change mid-frame while digit 3 is scanned
        waitFramePos(0, "coh_sync");
        applyStimulus(32'h11111111, 1'b0, 3'd0);
        stepCycles(FRM, "coh_a");
        waitFramePos(13, "coh_mid");
        applyStimulus(32'h22222222, 1'b0, 3'd0);
        checkDigit(5, 7'b1111001, "coh_old");
        stepCycles(2 * FRM, "coh_b");
        checkDigit(5, 7'b0100100, "coh_new");

        // Invalid BCD digit shows a dash
        applyStimulus(32'h0000000F, 1'b0, 3'd0);
        stepCycles(2 * FRM, "inval");
        checkDigit(0, 7'b0111111, "inval_d0");

        // Blink on digit 5, then edit mode off
        applyStimulus(32'h99999999, 1'b1, 3'd5);
        stepCycles(6 * FRM, "blink_on");
        applyStimulus(32'h99999999, 1'b0, 3'd5);
        stepCycles(4 * FRM, "blink_off");

        // Randomized values, edit mode and digit selection
        for (int it = 0; it < 24; it++) begin
            r = $urandom() >> (4 * $urandom_range(0, 7));
            applyStimulus(r, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            stepCycles($urandom_range(3, 48), "rand");
        end
        applyStimulus(32'h12345678, 1'b0, 3'd0);

        // Asynchronous reset while digit 4 is lit
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 2 * FRM; i++) begin
                @(negedge clk);
                checkOutput("pre_rst");
                if (exp_an == 8'hEF) begin
                    seen = 1'b1;
                    break;
                end
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL pre_rst timeout observed=none expected=an_ef");
            end else begin
                #2 rst = 1'b1;
                #1;
                assert (an === 8'hFF && seg === 7'h7F) else begin
                    errors++;
                    $error("[TB] FAIL async_rst an/seg observed=%h/%b expected=ff/1111111", an, seg);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        stepCycles(2 * FRM, "post_rst");

`ifdef LEADING_ZERO_BLANK_EN
        applyStimulus(32'h00000305, 1'b0, 3'd0);
        stepCycles(2 * FRM, "lz");
        checkDigit(7, 7'h7F, "lz_d7");
        checkDigit(3, 7'h7F, "lz_d3");
        checkDigit(2, 7'b0110000, "lz_d2");
        checkDigit(1, 7'b1000000, "lz_d1");
        checkDigit(0, 7'b0010010, "lz_d0");
        applyStimulus(32'h00000000, 1'b0, 3'd0);
        stepCycles(2 * FRM, "lz_zero");
        checkDigit(1, 7'h7F, "lz0_d1");
        checkDigit(0, 7'b1000000, "lz0_d0");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
